// File: rtl/neuron_pkg.sv
// Shared widths, target encodings, sample layout and feeder states for the
// neuron training data path.
package neuron_pkg;

  localparam int unsigned X_W      = 7;
  localparam int unsigned T_W      = 2;
  localparam int unsigned W_W      = 14;
  localparam int unsigned SAMPLE_W = 2 * X_W + T_W;

  localparam logic [T_W-1:0] T_POS = 2'b01;
  localparam logic [T_W-1:0] T_NEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    STREAM,
    FINISH
  } feeder_state_e;

  typedef struct packed {
    logic [X_W-1:0] x1;
    logic [X_W-1:0] x2;
    logic [T_W-1:0] t;
  } sample_t;

endpackage

// File: rtl/sample_ram.sv
// Single write port, combinational read port sample storage (contents not reset).
module sample_ram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/neuron_sample_feeder.sv
// Feeds stored (x1, x2, t) samples cyclically to a neuron after a start/n_bus
// handshake, then captures the trained weights or reports an epoch timeout.
module neuron_sample_feeder
  import neuron_pkg::*;
#(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned MAX_EPOCHS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [X_W-1:0]    wr_x1,
  input  logic [X_W-1:0]    wr_x2,
  input  logic [T_W-1:0]    wr_t,
  input  logic [ADDR_W:0]   sample_count,
  input  logic              go,
  output logic              busy,
  output logic [X_W-1:0]    x1_bus,
  output logic [X_W-1:0]    x2_bus,
  output logic [T_W-1:0]    t_bus,
  output logic [31:0]       n_bus,
  output logic              start,
  input  logic              done_in,
  input  logic [W_W-1:0]    w1_in,
  input  logic [W_W-1:0]    w2_in,
  input  logic [W_W-1:0]    bias_in,
  output logic [W_W-1:0]    w1_out,
  output logic [W_W-1:0]    w2_out,
  output logic [W_W-1:0]    bias_out,
  output logic              result_valid,
  output logic              timeout,
  output logic [6:0]        epoch
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned EP_RAW = $clog2(MAX_EPOCHS + 1);
  localparam int unsigned EP_W   = (EP_RAW > 7) ? EP_RAW : 7;

  feeder_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [EP_W-1:0]   r_ep;

  sample_t           w_rd;
  sample_t           w_wdata;
  logic              w_we;
  logic              w_go_ok;
  logic              w_wrap;
  logic              w_last_epoch;
  logic [EP_W-1:0]   w_ep_inc;

  // Display copy of the internal epoch count, clamped to the 7-bit port.
  function automatic logic [6:0] sat_epoch(input logic [EP_W-1:0] v);
    return (v > EP_W'(127)) ? 7'd127 : v[6:0];
  endfunction

  // The memory is frozen while it is being streamed from.
  assign w_wdata = {wr_x1, wr_x2, wr_t};
  assign w_we    = wr_en && (r_state != STREAM) && (CNT_W'(wr_addr) < CNT_W'(DEPTH));

  sample_ram #(
    .DEPTH (DEPTH),
    .DATA_W(SAMPLE_W),
    .ADDR_W(ADDR_W)
  ) u_sample_ram (
    .clk  (clk),
    .we   (w_we),
    .waddr(wr_addr),
    .wdata(w_wdata),
    .raddr(r_idx),
    .rdata(w_rd)
  );

  assign w_go_ok      = go && (sample_count != '0) && (sample_count <= CNT_W'(DEPTH));
  assign w_wrap       = (CNT_W'(r_idx) == (r_cnt - CNT_W'(1)));
  assign w_ep_inc     = r_ep + EP_W'(1);
  assign w_last_epoch = (w_ep_inc == EP_W'(MAX_EPOCHS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_ep         <= '0;
      busy         <= 1'b0;
      x1_bus       <= '0;
      x2_bus       <= '0;
      t_bus        <= '0;
      n_bus        <= '0;
      start        <= 1'b0;
      w1_out       <= '0;
      w2_out       <= '0;
      bias_out     <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      epoch        <= '0;
    end else begin
      start        <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go_ok) begin
            r_cnt   <= sample_count;
            busy    <= 1'b1;
            r_state <= ARM;
          end
        end
        ARM: begin
          start   <= 1'b1;
          n_bus   <= 32'(r_cnt);
          x1_bus  <= '0;
          x2_bus  <= '0;
          t_bus   <= '0;
          r_idx   <= '0;
          r_ep    <= '0;
          epoch   <= '0;
          r_state <= STREAM;
        end
        STREAM: begin
          if (done_in) begin
            // Completion wins over a simultaneous final-epoch wrap.
            w1_out       <= w1_in;
            w2_out       <= w2_in;
            bias_out     <= bias_in;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            x1_bus       <= '0;
            x2_bus       <= '0;
            t_bus        <= '0;
            n_bus        <= '0;
            r_state      <= FINISH;
          end else begin
            x1_bus <= w_rd.x1;
            x2_bus <= w_rd.x2;
            t_bus  <= w_rd.t;
            if (w_wrap) begin
              r_idx <= '0;
              r_ep  <= w_ep_inc;
              epoch <= sat_epoch(w_ep_inc);
              if (w_last_epoch) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
                r_state <= FINISH;
              end
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end
        end
        FINISH: begin
          x1_bus  <= '0;
          x2_bus  <= '0;
          t_bus   <= '0;
          n_bus   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Self-checking bench for neuron_sample_feeder: go-acceptance table plus a
// scoreboard of expected stream samples for the multi-cycle sequences.
module tb_neuron_sample_feeder;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned MAXEP  = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [6:0]  wr_x1;
  logic [6:0]  wr_x2;
  logic [1:0]  wr_t;
  logic [9:0]  sample_count;
  logic        go;
  logic        busy;
  logic [6:0]  x1_bus;
  logic [6:0]  x2_bus;
  logic [1:0]  t_bus;
  logic [31:0] n_bus;
  logic        start;
  logic        done_in;
  logic [13:0] w1_in;
  logic [13:0] w2_in;
  logic [13:0] bias_in;
  logic [13:0] w1_out;
  logic [13:0] w2_out;
  logic [13:0] bias_out;
  logic        result_valid;
  logic        timeout;
  logic [6:0]  epoch;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem_m [DEPTH];
  logic [25:0] exp_q [$];
  logic [13:0] last_w1, last_w2, last_b;

  typedef struct {
    logic [9:0]  cnt;
    logic        exp_acc;
    logic [31:0] exp_n;
    logic [13:0] w1;
    logic [13:0] w2;
    logic [13:0] b;
  } vec_t;

  vec_t tbl [5];

  neuron_sample_feeder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .MAX_EPOCHS(MAXEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_x1       (wr_x1),
    .wr_x2       (wr_x2),
    .wr_t        (wr_t),
    .sample_count(sample_count),
    .go          (go),
    .busy        (busy),
    .x1_bus      (x1_bus),
    .x2_bus      (x2_bus),
    .t_bus       (t_bus),
    .n_bus       (n_bus),
    .start       (start),
    .done_in     (done_in),
    .w1_in       (w1_in),
    .w2_in       (w2_in),
    .bias_in     (bias_in),
    .w1_out      (w1_out),
    .w2_out      (w2_out),
    .bias_out    (bias_out),
    .result_valid(result_valid),
    .timeout     (timeout),
    .epoch       (epoch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int x1, input int x2, input int t);
    wr_en   = 1'b1;
    wr_addr = 9'(a);
    wr_x1   = 7'(x1);
    wr_x2   = 7'(x2);
    wr_t    = 2'(t);
    tick();
    wr_en   = 1'b0;
    mem_m[a] = {7'(x1), 7'(x2), 2'(t)};
  endtask

  // Launch a run and compare n stream cycles; optionally poke go and a write mid-stream.
  task automatic run(input int cnt, input int n, input bit interfere);
    logic [25:0] e;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({3'b000, mem_m[k % cnt], 7'((k + 1) / cnt)});
    end
    sample_count = 10'(cnt);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_after_go", 64'(busy), 64'd1);
    chk("start_early", 64'(start), 64'd0);
    tick();
    chk("start", 64'(start), 64'd1);
    chk("n_bus", 64'(n_bus), 64'(cnt));
    chk("arm_buses", 64'({x1_bus, x2_bus, t_bus}), 64'd0);
    for (int k = 0; k < n; k++) begin
      tick();
      if (interfere && k == 0) begin
        go = 1'b1;
        sample_count = 10'd1;
        wr_en = 1'b1;
        wr_addr = 9'd0;
        wr_x1 = 7'h2A;
        wr_x2 = 7'h15;
        wr_t = 2'b01;
      end else if (interfere && k == 1) begin
        go = 1'b0;
        wr_en = 1'b0;
      end
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream", 64'({timeout, result_valid, start, x1_bus, x2_bus, t_bus, epoch}), 64'(e));
      end
    end
  endtask

  task automatic finish_done(input logic [13:0] w1, input logic [13:0] w2, input logic [13:0] b);
    w1_in = w1;
    w2_in = w2;
    bias_in = b;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("result_valid", 64'(result_valid), 64'd1);
    chk("no_timeout", 64'(timeout), 64'd0);
    chk("w_out", 64'({w1_out, w2_out, bias_out}), 64'({w1, w2, b}));
    chk("busy_done", 64'(busy), 64'd0);
    chk("buses_done", 64'({x1_bus, x2_bus, t_bus, n_bus}), 64'd0);
    tick();
    chk("rv_pulse", 64'({result_valid, timeout}), 64'd0);
    last_w1 = w1;
    last_w2 = w2;
    last_b  = b;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_t = '0;
    sample_count = '0; go = 1'b0; done_in = 1'b0;
    w1_in = '0; w2_in = '0; bias_in = '0;
    last_w1 = '0; last_w2 = '0; last_b = '0;

    tbl[0] = '{cnt: 10'd0,   exp_acc: 1'b0, exp_n: 32'd0,   w1: 14'h0000, w2: 14'h0000, b: 14'h0000};
    tbl[1] = '{cnt: 10'd3,   exp_acc: 1'b1, exp_n: 32'd3,   w1: 14'h0456, w2: 14'h3FF0, b: 14'h0010};
    tbl[2] = '{cnt: 10'd513, exp_acc: 1'b0, exp_n: 32'd0,   w1: 14'h0000, w2: 14'h0000, b: 14'h0000};
    tbl[3] = '{cnt: 10'd512, exp_acc: 1'b1, exp_n: 32'd512, w1: 14'h1FFF, w2: 14'h2000, b: 14'h3FFF};
    tbl[4] = '{cnt: 10'd1,   exp_acc: 1'b1, exp_n: 32'd1,   w1: 14'h0001, w2: 14'h0002, b: 14'h0003};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 64'({busy, x1_bus, x2_bus, t_bus, n_bus, start}), 64'd0);
    chk("reset_b", 64'({w1_out, w2_out, bias_out, result_valid, timeout, epoch}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic handshake and completion.
    wr(0, -16, -16, -1);
    wr(1, 5, 7, 1);
    wr(2, 1, -2, -1);
    run(3, 4, 1'b0);
    finish_done(14'h0123, 14'(-7), 14'd2);

    // Timeout: two samples, four epochs, no done.
    run(2, 7, 1'b0);
    tick();
    chk("timeout_pulse", 64'({timeout, result_valid}), 64'b10);
    chk("timeout_epoch", 64'(epoch), 64'(MAXEP));
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_w_kept", 64'({w1_out, w2_out, bias_out}), 64'({last_w1, last_w2, last_b}));
    tick();
    chk("timeout_end", 64'({timeout, x1_bus, n_bus}), 64'd0);

    // go and writes during STREAM are ignored; sample 0 must survive.
    run(3, 4, 1'b1);
    finish_done(14'h0AAA, 14'h3555, 14'h0001);
    run(3, 1, 1'b0);
    finish_done(14'h0042, 14'h0043, 14'h0044);

    // cnt = 1, with done on the final-epoch wrap.
    run(1, 3, 1'b0);
    finish_done(14'h0777, 14'h0888, 14'h0999);

    // Full memory, wrap from 511 to 0.
    for (int i = 0; i < 512; i++) begin
      wr(i, i % 128, 127 - (i % 128), (i % 2 == 1) ? 3 : 1);
    end
    run(512, 514, 1'b0);
    finish_done(14'h1234, 14'h2345, 14'h3456);

    // go acceptance table.
    for (int v = 0; v < 5; v++) begin
      sample_count = tbl[v].cnt;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("tbl_busy", 64'(busy), 64'(tbl[v].exp_acc));
      tick();
      chk("tbl_start", 64'(start), 64'(tbl[v].exp_acc));
      chk("tbl_n_bus", 64'(n_bus), 64'(tbl[v].exp_n));
      if (tbl[v].exp_acc) begin
        tick();
        chk("tbl_sample0", 64'({x1_bus, x2_bus, t_bus}), 64'(mem_m[0]));
        finish_done(tbl[v].w1, tbl[v].w2, tbl[v].b);
      end else begin
        tick();
        chk("tbl_rejected", 64'({busy, result_valid, timeout, w1_out, w2_out, bias_out}),
            64'({3'b000, last_w1, last_w2, last_b}));
      end
    end

    // Asynchronous reset in the middle of a stream.
    wr(0, 3, -3, 1);
    wr(1, -64, 63, -1);
    wr(2, 0, 1, 1);
    wr(3, 10, -10, -1);
    run(4, 2, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", 64'({busy, x1_bus, x2_bus, t_bus, n_bus, start}), 64'd0);
    chk("async_rst_b", 64'({w1_out, w2_out, bias_out, result_valid, timeout, epoch}), 64'd0);
    last_w1 = '0; last_w2 = '0; last_b = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", 64'({busy, start, result_valid, timeout}), 64'd0);
    end
    run(4, 3, 1'b0);
    finish_done(14'h0005, 14'h0006, 14'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_sample_feeder.md
Name: neuron_sample_feeder

Overview:
Sample source and result collector for neuron_module training. It holds a dataset of (x1, x2, t) samples loaded through a write port. On go, it issues the start/n_bus handshake to the neuron, then streams samples cyclically, epoch after epoch, until the neuron raises done. It then captures the trained W1, W2 and Bias. It sits between the host/loader and neuron_module.

Parameters:
DEPTH, 512, sample memory entries
ADDR_W, 9, log2(DEPTH)
X_W, 7, signed input sample width
T_W, 2, signed target width
W_W, 14, signed weight/bias width
MAX_EPOCHS, 64, epoch limit before timeout

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  sample write strobe
wr_addr  in  ADDR_W  sample write address
wr_x1  in  X_W  signed x1 of written sample
wr_x2  in  X_W  signed x2 of written sample
wr_t  in  T_W  signed target of written sample (+1 = 01, -1 = 11)
sample_count  in  ADDR_W+1  number of valid samples, 0..DEPTH
go  in  1  launch training (1-cycle pulse)
busy  out  1  high from the cycle after go is accepted until return to IDLE
x1_bus  out  X_W  sample x1 to neuron
x2_bus  out  X_W  sample x2 to neuron
t_bus  out  T_W  sample target to neuron
n_bus  out  32  sample count to neuron, zero-extended
start  out  1  neuron start strobe
done_in  in  1  neuron training complete
w1_in, w2_in, bias_in  in  W_W each  signed neuron results
w1_out, w2_out, bias_out  out  W_W each  captured results
result_valid  out  1  1-cycle pulse: results captured
timeout  out  1  1-cycle pulse: MAX_EPOCHS exhausted without done_in
epoch  out  7  completed-epoch counter (saturating display of internal count)

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous, active-low.
- Reset values: all outputs are 0, state = IDLE, idx = 0, epoch = 0. Sample memory contents are not reset.
- Reset asserted mid-operation aborts immediately. No result_valid or timeout is produced.
- All outputs are registered.
- Memory: DEPTH x (2*X_W + T_W).
  - Written in any state except STREAM, when wr_en = 1 and wr_addr < DEPTH. Other writes are ignored.
  - Read is combinational from idx, into registered bus outputs.
- IDLE:
  - go = 1 and 1 <= sample_count <= DEPTH: latch cnt = sample_count, move to ARM.
  - Otherwise go is ignored.
  - go while not in IDLE is ignored.
- ARM (exactly 1 cycle of outputs):
  - Next-cycle outputs: start = 1, n_bus = cnt, x/t buses = 0, busy = 1.
  - idx = 0, epoch = 0. Move to STREAM.
- STREAM:
  - Each cycle presents sample idx on x1_bus/x2_bus/t_bus with start = 0. The first sample appears the cycle after start.
  - idx increments each cycle. At idx = cnt-1 it wraps to 0 and epoch increments.
  - n_bus holds cnt throughout.
- done_in = 1 in STREAM:
  - Capture w1_in/w2_in/bias_in into the output registers on that edge.
  - result_valid = 1 for the next cycle. Move to IDLE.
  - Buses are zeroed.
  - done_in takes priority over timeout in the same cycle.
- Timeout: wrap with epoch+1 = MAX_EPOCHS and done_in = 0 gives timeout pulse = 1, move to IDLE. Previous w*_out values are retained.
- done_in outside STREAM is ignored.
- w*_out hold their value until the next capture or reset.
- cnt = 1: the same sample repeats every cycle and epoch increments every cycle.
- cnt = DEPTH: idx wraps from DEPTH-1 to 0. No out-of-range read.
- States: IDLE, ARM, STREAM, FINISH. FINISH is a 1 cycle that drives the pulse, then returns to IDLE.
- Latency: go to start = 2 cycles. done_in to result_valid = 1 cycle.

Decomposition:
- Shared package neuron_pkg:
  - constants X_W, T_W, W_W;
  - target encodings T_POS = 2'b01, T_NEG = 2'b11;
  - feeder state enum {IDLE, ARM, STREAM, FINISH}.
- One sub-module: sample_ram, a single write port with combinational read port, parameterised on DEPTH and data width.
- FSM, counters and capture registers stay in the top module.

Test Plan:
- Reset mid-stream: load 4 samples, go, assert rst_n = 0 in STREAM cycle 3 -> all outputs 0 asynchronously; no pulse after release; busy = 0.
- Basic handshake: write 3 samples {(-16, -16, -1), (5, 7, +1), (1, -2, -1)}, sample_count = 3, go -> 2 cycles later start = 1 and n_bus = 3; next cycles present x1_bus = 7'b1110000, then 5, then 1, then -16 again; epoch steps 0 -> 1 on the wrap.
- Completion: with the same data, drive done_in = 1 in STREAM cycle 5 with w1_in = 14'h0123, w2_in = -7, bias_in = 2 -> next cycle result_valid = 1, w1_out = 0x0123, w2_out = -7, bias_out = 2; busy = 0; buses = 0.
- Timeout: MAX_EPOCHS = 4, sample_count = 2, done_in held 0 -> timeout pulse after exactly 1 + 8 STREAM cycles; w*_out unchanged from the prior run.
- Illegal go: go with sample_count = 0, then go while busy, then wr_en during STREAM -> no state change, no start, memory unchanged (verified by a later run).
- Boundary: cnt = 1 -> the same sample every cycle and epoch increments each cycle; cnt = 512 with all addresses written -> idx 511 is followed by 0; done_in coinciding with the timeout wrap -> result_valid only.
